load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-addressed data memory with a
// registered read port. Sub-word stores use read-modify-write; misaligned requests
// complete immediately with an error flag and touch no memory.
module load_store_unit #(
  parameter int unsigned WORD_BITS = 8
) (
  input  logic        LSU_clk,
  input  logic        LSU_reset,
  input  logic        LSU_req,
  input  logic        LSU_we,
  input  logic [1:0]  LSU_size,
  input  logic        LSU_signed,
  input  logic [31:0] LSU_addr,
  input  logic [31:0] LSU_wdata,
  output logic [31:0] LSU_rdata,
  output logic        LSU_busy,
  output logic        LSU_done,
  output logic        LSU_misaligned,
  output logic [31:0] LSU_mem_address,
  output logic [31:0] LSU_mem_data_out,
  output logic        LSU_mem_write,
  output logic        LSU_mem_read,
  input  logic [31:0] LSU_mem_data_in
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [2:0] {StIdle, StRd, StLdCap, StMrg, StWr, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [WORD_BITS+1:0] r_addr;
  logic [31:0]         r_wdata;
  logic [1:0]          r_size;
  logic                r_signed;
  logic                r_we;
  logic                r_mis;
  logic [31:0]         r_merged;
  logic [31:0]         r_rdata;

  logic                w_accept;
  logic                w_mis;
  logic [31:0]         w_word_idx;
  logic [15:0]         w_lane;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;
  logic                w_unused_addr;

  // Address bits above the memory's reach are intentionally ignored.
  assign w_unused_addr = ^LSU_addr[31:WORD_BITS+2];

  assign w_accept = (r_state == StIdle) && LSU_req;
  assign w_mis    = (LSU_size == 2'b11) ||
                    ((LSU_size == SizeHalf) && LSU_addr[0]) ||
                    ((LSU_size == SizeWord) && (LSU_addr[1:0] != 2'b00));
  assign w_word_idx = {{(32 - WORD_BITS){1'b0}}, r_addr[WORD_BITS+1:2]};

  // State register
  always_ff @(posedge LSU_clk or posedge LSU_reset) begin
    if (LSU_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (LSU_req) begin
          if (w_mis) begin
            w_state_next = StDone;
          end else if (LSU_we && (LSU_size == SizeWord)) begin
            w_state_next = StWr;
          end else begin
            w_state_next = StRd;
          end
        end
      end
      StRd:    w_state_next = r_we ? StMrg : StLdCap;
      StLdCap: w_state_next = StDone;
      StMrg:   w_state_next = StWr;
      StWr:    w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output decode, from state only
  always_comb begin
    LSU_busy         = 1'b1;
    LSU_done         = 1'b0;
    LSU_misaligned   = 1'b0;
    LSU_mem_read     = 1'b0;
    LSU_mem_write    = 1'b0;
    LSU_mem_address  = '0;
    LSU_mem_data_out = '0;
    unique case (r_state)
      StIdle: LSU_busy = 1'b0;
      StRd: begin
        LSU_mem_read    = 1'b1;
        LSU_mem_address = w_word_idx;
      end
      StWr: begin
        LSU_mem_write    = 1'b1;
        LSU_mem_address  = w_word_idx;
        LSU_mem_data_out = (r_size == SizeWord) ? r_wdata : r_merged;
      end
      StDone: begin
        LSU_done       = 1'b1;
        LSU_misaligned = r_mis;
      end
      default: ;
    endcase
  end

  // Load lane extraction; halves are aligned so the shift is 0 or 16 for them.
  always_comb begin
    w_lane = 16'(LSU_mem_data_in >> {r_addr[1:0], 3'b000});
    w_load = LSU_mem_data_in;
    case (r_size)
      SizeByte: w_load = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      SizeHalf: w_load = {{16{r_signed & w_lane[15]}}, w_lane};
      default:  w_load = LSU_mem_data_in;
    endcase
  end

  // Read-modify-write merge of the store lane into the fetched word
  always_comb begin
    w_merged = LSU_mem_data_in;
    if (r_size == SizeByte) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // Request latch and datapath registers
  always_ff @(posedge LSU_clk or posedge LSU_reset) begin
    if (LSU_reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_merged <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= LSU_addr[WORD_BITS+1:0];
        r_wdata  <= LSU_wdata;
        r_size   <= LSU_size;
        r_signed <= LSU_signed;
        r_we     <= LSU_we;
        r_mis    <= w_mis;
      end
      if (r_state == StMrg) begin
        r_merged <= w_merged;
      end
      if (r_state == StLdCap) begin
        r_rdata <= w_load;
      end
    end
  end

  assign LSU_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural data memory, expected
// completions and memory writes queued at issue and retired by a negedge monitor.
module tb_load_store_unit;

  typedef struct {
    logic        mis;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        mis;
  logic [31:0] mem_address;
  logic [31:0] mem_dout;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rd;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] model_rdata;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_reads = 0;
  int n_dones = 0;

  load_store_unit #(.WORD_BITS(8)) dut (
    .LSU_clk         (clk),
    .LSU_reset       (rst),
    .LSU_req         (req),
    .LSU_we          (we),
    .LSU_size        (size),
    .LSU_signed      (sgn),
    .LSU_addr        (addr),
    .LSU_wdata       (wdata),
    .LSU_rdata       (rdata),
    .LSU_busy        (busy),
    .LSU_done        (done),
    .LSU_misaligned  (mis),
    .LSU_mem_address (mem_address),
    .LSU_mem_data_out(mem_dout),
    .LSU_mem_write   (mem_write),
    .LSU_mem_read    (mem_read),
    .LSU_mem_data_in (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_read) mem_rd <= mem[mem_address[7:0]];
    if (mem_write) mem[mem_address[7:0]] <= mem_dout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model one request accepted on the edge after cycle n.
  task automatic push_exp(input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] d, input int n);
    exp_t        e;
    wr_t         wr;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] m;
    int          sh;
    word = ref_mem[a[9:2]];
    sh   = 8 * int'(a[1:0]);
    e.mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (e.mis) begin
      e.done_cyc = n + 1;
    end else if (!w) begin
      e.done_cyc = n + 3;
      if (sz == 2'b00) begin
        v = (word >> sh) & 32'hFF;
        if (s && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = (word >> sh) & 32'hFFFF;
        if (s && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
      model_rdata = v;
    end else begin
      e.done_cyc = (sz == 2'b10) ? n + 2 : n + 4;
      m = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      v = (sz == 2'b10) ? d : ((word & ~m) | ((d << sh) & m));
      wr.addr = {24'h0, a[9:2]};
      wr.data = v;
      wr_q.push_back(wr);
      ref_mem[a[9:2]] = v;
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && wr_q.size() == 0 && !busy) return;
    end
    check({tag, "_timeout"}, 32'd1, 32'd0);
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = d;
    push_exp(w, sz, s, a, d, cyc);
    @(negedge clk);
    req = 1'b0;
    wait_idle(tag);
  endtask

  // Monitor: per-cycle invariants plus scoreboard retirement
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rw_excl", {31'b0, mem_read & mem_write}, 32'd0);
        if (!mem_read && !mem_write) begin
          check("addr_idle", mem_address, 32'd0);
          check("dout_idle", mem_dout, 32'd0);
        end
        if (mem_read) n_reads++;
        if (mem_write) begin
          if (wr_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
          end else begin
            w = wr_q.pop_front();
            check("wr_addr", mem_address, w.addr);
            check("wr_data", mem_dout, w.data);
          end
        end
        if (done) begin
          n_dones++;
          if (exp_q.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("misaligned", {31'b0, mis}, {31'b0, e.mis});
            check("rdata", rdata, e.rdata);
            check("latency", cyc, e.done_cyc);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int r0;
    int d0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0;
    addr = '0; wdata = '0; model_rdata = '0;
    #1;
    check("rst_ctl", {27'b0, busy, done, mis, mem_read, mem_write}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First request right after reset release
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_deadbeef");
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_1234, "sw_w4");
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, "sw_w8");

    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lb");
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lbu");
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, "lhu");
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "lh_hi");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_w4");

    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, "sh_hi");
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw_w8");
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_AA55, "sb_b1");
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "lbu_b1");

    // Misaligned and reserved-size requests
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, "lw_mis");
    issue(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, "lh_mis");
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, "rsvd_size");
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, "sw_mis");
    issue(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF, "sh_mis");
    check("mem_w4_final", mem[4], ref_mem[4]);

    // Request held high across two loads
    @(negedge clk);
    n  = cyc;
    r0 = n_reads;
    d0 = n_dones;
    req = 1'b1; we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h10;
    push_exp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, n);
    push_exp(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, n + 4);
    @(negedge clk);
    addr = 32'h20;
    repeat (4) @(negedge clk);
    req = 1'b0;
    wait_idle("b2b");
    check("b2b_reads", n_reads - r0, 32'd2);
    check("b2b_dones", n_dones - d0, 32'd2);

    // Reset while the byte store sits in MRG
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 32'h21; wdata = 32'h77;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ctl", {27'b0, busy, done, mis, mem_read, mem_write}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_addr", mem_address, 32'd0);
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_w8_kept", mem[8], ref_mem[8]);
    check("abort_idle", {31'b0, busy}, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw_after_abort");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
